burst_ram_arbiter: RTL

// Shares one BurstRAM between two cache requesters (p0 = instruction cache, p1 = data cache).

---
 rtl/burst_ram_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/burst_ram_arbiter.sv
// -----------------------------------------------------------------------------
// burst_ram_arbiter
//
// Shares one BurstRAM between two cache requesters (p0 = instruction cache,
// p1 = data cache). Each port has a one-deep command slot. Whole bursts are
// granted round-robin. Write beats and masks are routed from the owner to the
// RAM, and read-valid strobes are routed from the RAM back to the owner. The
// block runs in the RAM clock domain.
//
// Ports (N = 0,1)
//   i_clk                 RAM clock, rising edge
//   i_rst_n               asynchronous reset, active low
//   i_pN_cmd              0 = read, 1 = write, sampled with i_pN_cmd_en
//   i_pN_cmd_en           one-cycle request strobe, taken only when o_pN_busy = 0
//   i_pN_addr             burst start address
//   i_pN_wr_data          current write beat (live)
//   i_pN_data_mask        current beat byte mask (live)
//   o_pN_wr_ack           write beat consumed this cycle
//   o_pN_rd_data_valid    read beat valid on the shared RAM read bus
//   o_pN_busy             request pending or in flight
//   o_br_cmd/_cmd_en/_addr/_wr_data/_data_mask   command and write path to the RAM
//   i_br_rd_data_valid    read beat strobe from the RAM
//   i_br_busy             RAM cannot accept a command
// -----------------------------------------------------------------------------
module burst_ram_arbiter #(
    parameter int ADDRESS_BITWIDTH = 8,
    parameter int DATA_BITWIDTH    = 64,
    parameter int BURST_COUNT      = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,

    input  logic                          i_p0_cmd,
    input  logic                          i_p0_cmd_en,
    input  logic [ADDRESS_BITWIDTH-1:0]   i_p0_addr,
    input  logic [DATA_BITWIDTH-1:0]      i_p0_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]    i_p0_data_mask,
    output logic                          o_p0_wr_ack,
    output logic                          o_p0_rd_data_valid,
    output logic                          o_p0_busy,

    input  logic                          i_p1_cmd,
    input  logic                          i_p1_cmd_en,
    input  logic [ADDRESS_BITWIDTH-1:0]   i_p1_addr,
    input  logic [DATA_BITWIDTH-1:0]      i_p1_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]    i_p1_data_mask,
    output logic                          o_p1_wr_ack,
    output logic                          o_p1_rd_data_valid,
    output logic                          o_p1_busy,

    output logic                          o_br_cmd,
    output logic                          o_br_cmd_en,
    output logic [ADDRESS_BITWIDTH-1:0]   o_br_addr,
    output logic [DATA_BITWIDTH-1:0]      o_br_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]    o_br_data_mask,
    input  logic                          i_br_rd_data_valid,
    input  logic                          i_br_busy
);

    // state  | meaning
    // IDLE   | wait for a pending slot and a free RAM, then pick the owner
    // ISSUE  | one-cycle command strobe to the RAM (write beat 0 goes out here too)
    // WRITE  | write beats 1..BURST_COUNT-1 on consecutive cycles
    // READ   | forward RAM read strobes to the owner until BURST_COUNT are seen

    localparam int MW = DATA_BITWIDTH / 8;
    localparam int CW = $clog2(BURST_COUNT) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    state_t                        r_state;
    logic [1:0]                    r_pend;
    logic [1:0]                    r_cmd;
    logic [ADDRESS_BITWIDTH-1:0]   r_addr0;
    logic [ADDRESS_BITWIDTH-1:0]   r_addr1;
    logic                          r_owner;
    logic                          r_last_grant;
    logic [CW-1:0]                 r_cnt;

    state_t                        w_state_nxt;
    logic                          w_owner_nxt;
    logic                          w_last_grant_nxt;
    logic [CW-1:0]                 w_cnt_nxt;
    logic                          w_done;
    logic                          w_issue;
    logic                          w_wr_beat;
    logic                          w_rd_fwd;
    logic [1:0]                    w_acc;

    logic                          w_own_cmd;
    logic [ADDRESS_BITWIDTH-1:0]   w_own_addr;
    logic [DATA_BITWIDTH-1:0]      w_own_wdata;
    logic [MW-1:0]                 w_own_mask;

    // A strobe is only taken into an empty slot; strobes against a full slot vanish.
    assign w_acc[0] = i_p0_cmd_en & ~r_pend[0];
    assign w_acc[1] = i_p1_cmd_en & ~r_pend[1];

    assign w_own_cmd   = r_owner ? r_cmd[1]       : r_cmd[0];
    assign w_own_addr  = r_owner ? r_addr1        : r_addr0;
    assign w_own_wdata = r_owner ? i_p1_wr_data   : i_p0_wr_data;
    assign w_own_mask  = r_owner ? i_p1_data_mask : i_p0_data_mask;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    // Command slots. A slot is released on the owner's final beat, so busy
    // drops on the following cycle; the release and a new accept can never hit
    // the same slot because an accept needs the slot to be empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend  <= 2'b00;
            r_cmd   <= 2'b00;
            r_addr0 <= '0;
            r_addr1 <= '0;
        end else begin
            if (w_done && !r_owner) begin
                r_pend[0] <= 1'b0;
            end else if (w_acc[0]) begin
                r_pend[0] <= 1'b1;
                r_cmd[0]  <= i_p0_cmd;
                r_addr0   <= i_p0_addr;
            end

            if (w_done && r_owner) begin
                r_pend[1] <= 1'b0;
            end else if (w_acc[1]) begin
                r_pend[1] <= 1'b1;
                r_cmd[1]  <= i_p1_cmd;
                r_addr1   <= i_p1_addr;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_cnt_nxt        = r_cnt;
        w_done           = 1'b0;
        w_issue          = 1'b0;
        w_wr_beat        = 1'b0;
        w_rd_fwd         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!i_br_busy && (r_pend != 2'b00)) begin
                    w_state_nxt = ST_ISSUE;
                    w_cnt_nxt   = '0;
                    if (r_pend == 2'b11) begin
                        // Only a tie moves the round-robin pointer.
                        w_owner_nxt      = ~r_last_grant;
                        w_last_grant_nxt = ~r_last_grant;
                    end else begin
                        w_owner_nxt = ~r_pend[0];
                    end
                end
            end

            ST_ISSUE: begin
                w_issue = 1'b1;
                if (w_own_cmd) begin
                    w_wr_beat   = 1'b1;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_READ;
                end
            end

            ST_WRITE: begin
                w_wr_beat = 1'b1;
                if (r_cnt == LAST_BEAT) begin
                    w_done      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            ST_READ: begin
                if (i_br_rd_data_valid) begin
                    w_rd_fwd = 1'b1;
                    if (r_cnt == LAST_BEAT) begin
                        w_done      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_br_cmd_en    = w_issue;
    assign o_br_cmd       = w_issue & w_own_cmd;
    assign o_br_addr      = w_issue ? w_own_addr : '0;
    assign o_br_wr_data   = w_wr_beat ? w_own_wdata : '0;
    assign o_br_data_mask = w_wr_beat ? w_own_mask : '0;

    assign o_p0_wr_ack        = w_wr_beat & ~r_owner;
    assign o_p1_wr_ack        = w_wr_beat &  r_owner;
    assign o_p0_rd_data_valid = w_rd_fwd  & ~r_owner;
    assign o_p1_rd_data_valid = w_rd_fwd  &  r_owner;
    assign o_p0_busy          = r_pend[0];
    assign o_p1_busy          = r_pend[1];

endmodule
